// File: rtl/chan_sel_mux_reg_if.sv
// Handshake/data bundle between N_CH producers, the channel mux, and one consumer.
interface chan_sel_mux_reg_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 4
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     mode;
    logic [SEL_W-1:0]         addr;
    logic [N_CH*DATA_W-1:0]   in_data;
    logic [N_CH-1:0]          in_valid;
    logic [N_CH-1:0]          in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_chan;
    logic                     out_valid;
    logic                     out_ready;

    // Producer/consumer side
    modport master (
        output mode, addr, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    // Mux side
    modport slave (
        input  mode, addr, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/chan_sel_mux_reg.sv
// Registered N-to-1 channel mux with address-select or round-robin grant and a single
// output pipeline stage carrying data plus the index of the source channel.
module chan_sel_mux_reg #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    chan_sel_mux_reg_if.slave   bus
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic               load_en;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic               xfer;
    int unsigned        pos;

    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_chan_q, out_chan_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Output stage is free now, or is being drained this cycle
    assign load_en = !out_valid_q || bus.out_ready;
    assign xfer    = load_en && grant_vld;

    // Grant selection: exact address match in mode 0, rotating priority from rr_ptr in mode 1
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        pos       = 0;
        if (!bus.mode) begin
            // Out-of-range addr matches no k, so it can never grant
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (bus.addr == SEL_W'(k) && bus.in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                pos = 32'(rr_ptr_q) + i;
                if (pos >= N_CH) pos = pos - N_CH;
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (!grant_vld && k == pos && bus.in_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(k);
                    end
                end
            end
        end
    end

    // One-hot ready toward the granted producer only
    always_comb begin
        bus.in_ready = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            bus.in_ready[k] = load_en && grant_vld && (grant_idx == SEL_W'(k));
        end
    end

    // Next-state for the output stage and the round-robin pointer
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (grant_idx == SEL_W'(k)) out_data_d = bus.in_data[k*DATA_W +: DATA_W];
            end
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                rr_ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_chan_sel_mux_reg.sv
// Directed bench: a 4-channel instance for most scenarios, a 3-channel one for out-of-range addr.
module tb_chan_sel_mux_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    chan_sel_mux_reg_if #(.N_CH(4), .DATA_W(4)) bus4 ();
    chan_sel_mux_reg_if #(.N_CH(3), .DATA_W(4)) bus3 ();

    chan_sel_mux_reg #(.N_CH(4), .DATA_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    chan_sel_mux_reg #(.N_CH(3), .DATA_W(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    // Channel k of bus4 carries 4'hA + k
    logic [3:0] exp4 [4];
    initial begin
        exp4[0] = 4'hA; exp4[1] = 4'hB; exp4[2] = 4'hC; exp4[3] = 4'hD;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.mode = 1'b0; bus4.addr = '0; bus4.in_data = 16'hDCBA; bus4.in_valid = '0;
        bus4.out_ready = 1'b0;
        bus3.mode = 1'b0; bus3.addr = '0; bus3.in_data = 12'h987; bus3.in_valid = '0;
        bus3.out_ready = 1'b0;
        step(); step();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b exp 0", bus4.out_valid); end
        checks++; if (bus4.out_data !== 4'h0) begin errors++;
            $display("FAIL reset_data got %h exp 0", bus4.out_data); end
        checks++; if (bus4.out_chan !== 2'd0) begin errors++;
            $display("FAIL reset_chan got %0d exp 0", bus4.out_chan); end
        checks++; if (bus3.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid3 got %b exp 0", bus3.out_valid); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mode0_sweep();
        bus4.mode = 1'b0; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus4.addr = 2'(a);
            #1;
            checks++; if (bus4.in_ready !== 4'(1 << a)) begin errors++;
                $display("FAIL m0_ready[%0d] got %b exp %b", a, bus4.in_ready, 4'(1 << a)); end
            step();
            checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== exp4[a]
                          || bus4.out_chan !== 2'(a)) begin errors++;
                $display("FAIL m0_out[%0d] got v%b d%h c%0d exp v1 d%h c%0d", a,
                         bus4.out_valid, bus4.out_data, bus4.out_chan, exp4[a], a); end
        end
        // Pop without refill: valid drops, data/chan hold
        bus4.in_valid = '0;
        step();
        checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 4'hD
                      || bus4.out_chan !== 2'd3) begin errors++;
            $display("FAIL m0_pop got v%b d%h c%0d exp v0 dD c3",
                     bus4.out_valid, bus4.out_data, bus4.out_chan); end
    endtask

    task automatic test_mode0_oor();
        bus3.mode = 1'b0; bus3.addr = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus3.in_ready !== 3'b000) begin errors++;
                $display("FAIL oor_ready got %b exp 000", bus3.in_ready); end
            step();
            checks++; if (bus3.out_valid !== 1'b0) begin errors++;
                $display("FAIL oor_valid got %b exp 0", bus3.out_valid); end
        end
        bus3.addr = 2'd2;
        #1;
        checks++; if (bus3.in_ready !== 3'b100) begin errors++;
            $display("FAIL n3_ready got %b exp 100", bus3.in_ready); end
        step();
        checks++; if (bus3.out_valid !== 1'b1 || bus3.out_data !== 4'h9
                      || bus3.out_chan !== 2'd2) begin errors++;
            $display("FAIL n3_out got v%b d%h c%0d exp v1 d9 c2",
                     bus3.out_valid, bus3.out_data, bus3.out_chan); end
        bus3.in_valid = '0;
        step();
    endtask

    task automatic test_rr_fairness();
        bus4.mode = 1'b1; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        #1;
        checks++; if (bus4.in_ready !== 4'b0001) begin errors++;
            $display("FAIL rr_first_ready got %b exp 0001", bus4.in_ready); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'(i % 4)
                          || bus4.out_data !== exp4[i % 4]) begin errors++;
                $display("FAIL rr_seq[%0d] got v%b c%0d d%h exp v1 c%0d d%h", i,
                         bus4.out_valid, bus4.out_chan, bus4.out_data, i % 4, exp4[i % 4]); end
        end
        bus4.in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'd2
                          || bus4.out_data !== 4'hC) begin errors++;
                $display("FAIL rr_only2[%0d] got v%b c%0d d%h exp v1 c2 dC", i,
                         bus4.out_valid, bus4.out_chan, bus4.out_data); end
        end
    endtask

    // Entered with rr_ptr = 3
    task automatic test_backpressure();
        bus4.mode = 1'b1; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        step();
        checks++; if (bus4.out_chan !== 2'd3 || bus4.out_data !== 4'hD) begin errors++;
            $display("FAIL bp_load got c%0d d%h exp c3 dD", bus4.out_chan, bus4.out_data); end
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus4.in_ready !== 4'b0000) begin errors++;
                $display("FAIL bp_ready[%0d] got %b exp 0000", i, bus4.in_ready); end
            step();
            checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 4'hD
                          || bus4.out_chan !== 2'd3) begin errors++;
                $display("FAIL bp_hold[%0d] got v%b d%h c%0d exp v1 dD c3", i,
                         bus4.out_valid, bus4.out_data, bus4.out_chan); end
        end
        bus4.out_ready = 1'b1;
        #1;
        checks++; if (bus4.in_ready !== 4'b0001) begin errors++;
            $display("FAIL bp_release_ready got %b exp 0001", bus4.in_ready); end
        step();
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'd0
                      || bus4.out_data !== 4'hA) begin errors++;
            $display("FAIL bp_refill got v%b c%0d d%h exp v1 c0 dA",
                     bus4.out_valid, bus4.out_chan, bus4.out_data); end
        bus4.in_valid = '0;
        step();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_drain got %b exp 0", bus4.out_valid); end
    endtask

    // Entered with rr_ptr = 1
    task automatic test_mode_switch();
        bus4.mode = 1'b1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b1;
        step();
        checks++; if (bus4.out_chan !== 2'd1) begin errors++;
            $display("FAIL ms_setup got c%0d exp c1", bus4.out_chan); end
        bus4.mode = 1'b0; bus4.addr = 2'd0; bus4.in_valid = 4'hF;
        #1;
        checks++; if (bus4.in_ready !== 4'b0001) begin errors++;
            $display("FAIL ms_m0_ready got %b exp 0001", bus4.in_ready); end
        step();
        checks++; if (bus4.out_chan !== 2'd0 || bus4.out_data !== 4'hA) begin errors++;
            $display("FAIL ms_m0_out got c%0d d%h exp c0 dA", bus4.out_chan, bus4.out_data); end
        bus4.mode = 1'b1;
        #1;
        checks++; if (bus4.in_ready !== 4'b0100) begin errors++;
            $display("FAIL ms_rr_ready got %b exp 0100", bus4.in_ready); end
        step();
        checks++; if (bus4.out_chan !== 2'd2 || bus4.out_data !== 4'hC) begin errors++;
            $display("FAIL ms_rr_out got c%0d d%h exp c2 dC", bus4.out_chan, bus4.out_data); end
    endtask

    // Async reset with a word in flight, no clock edge between assert and check
    task automatic test_reset_midstream();
        bus4.mode = 1'b1; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        step();
        checks++; if (bus4.out_valid !== 1'b1) begin errors++;
            $display("FAIL mid_preload got %b exp 1", bus4.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 4'h0
                      || bus4.out_chan !== 2'd0) begin errors++;
            $display("FAIL mid_reset got v%b d%h c%0d exp v0 d0 c0",
                     bus4.out_valid, bus4.out_data, bus4.out_chan); end
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (bus4.in_ready !== 4'b0001) begin errors++;
            $display("FAIL mid_rrptr got %b exp 0001", bus4.in_ready); end
        bus4.in_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_mode0_sweep();
        test_mode0_oor();
        test_rr_fairness();
        test_backpressure();
        test_mode_switch();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
